// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory access unit.
//   dmem_state_t : access FSM states (IDLE, ACCESS)
//   dmem_req_t   : one queued load/store request
// The request struct is sized from the DMEM_* constants below, so a
// different address/data/tag width is changed here, not only on the top.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_TAG_W  = 5;
    localparam int DMEM_CNT_W  = 8;
    localparam int DMEM_DEPTH  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } dmem_state_t;

    typedef struct packed {
        logic                   is_store;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [DMEM_TAG_W-1:0]  tag;
    } dmem_req_t;

endpackage

// File: rtl/data_mem_access_unit_req_fifo.sv
// Small synchronous FIFO for queued memory requests.
//   CLK, RST     : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : write din when not full
//   pop, dout    : dout is the head entry; pop advances when not empty
//   full, empty  : occupancy flags
//   count        : entries held (0..DEPTH)
// DEPTH must be a power of 2 so the pointers wrap naturally.
module req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// Initiator side of the data-memory interface.
//   CLK, RST                      : clock, synchronous active-high reset
//   req_valid/req_ready/req_*     : load/store request handshake into a FIFO
//   writeEn/readEn/ALUMemAdd/
//   writeDataM/readDataW          : one-cycle access toward data memory
//   resp_valid/resp_*             : single-cycle tagged response to writeback
//   busy                          : work queued or an access in flight
//   store_count                   : saturating count of successful stores
// Out-of-range requests never raise a strobe; they still get a response
// with resp_err set.
module data_mem_access_unit
    import dmem_pkg::*;
#(
    parameter int DATA_BASE_ADD    = 5,
    parameter int OUTPUT_FILE_SIZE = 4,
    parameter int IN_BUS_WIDTH     = DMEM_ADDR_W,
    parameter int MEMORY_WIDTH     = DMEM_DATA_W,
    parameter int ADDRESS_SIZE     = 20,
    parameter int TAG_WIDTH        = DMEM_TAG_W,
    parameter int REQ_DEPTH        = DMEM_DEPTH,
    parameter int CNT_WIDTH        = DMEM_CNT_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_is_store,
    input  logic [IN_BUS_WIDTH-1:0] req_addr,
    input  logic [MEMORY_WIDTH-1:0] req_wdata,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    output logic                    writeEn,
    output logic                    readEn,
    output logic [IN_BUS_WIDTH-1:0] ALUMemAdd,
    output logic [MEMORY_WIDTH-1:0] writeDataM,
    input  logic [MEMORY_WIDTH-1:0] readDataW,
    output logic                    resp_valid,
    output logic                    resp_is_store,
    output logic [TAG_WIDTH-1:0]    resp_tag,
    output logic [MEMORY_WIDTH-1:0] resp_data,
    output logic                    resp_err,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    store_count
);

    // Load legality is checked against the pre-subtracted limit so the
    // unsigned compare never has to form addr+DATA_BASE_ADD.
    localparam logic [IN_BUS_WIDTH-1:0] STORE_MAX = IN_BUS_WIDTH'(OUTPUT_FILE_SIZE);
    localparam logic [IN_BUS_WIDTH-1:0] LOAD_LIM  = IN_BUS_WIDTH'(ADDRESS_SIZE - DATA_BASE_ADD);

    dmem_state_t                   state, state_nxt;
    dmem_req_t                     push_req, head;
    logic [$bits(dmem_req_t)-1:0]  head_bits;
    logic                          full, empty, push, pop, head_ok;
    logic [$clog2(REQ_DEPTH):0]    fifo_cnt;

    // Request in flight, kept for the response edge.
    logic                          cur_is_store, cur_err;
    logic [TAG_WIDTH-1:0]          cur_tag;

    assign push_req  = '{is_store: req_is_store, addr: req_addr,
                         wdata: req_wdata, tag: req_tag};
    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && !empty;
    assign head      = dmem_req_t'(head_bits);
    assign head_ok   = head.is_store ? (head.addr <= STORE_MAX)
                                     : (head.addr <  LOAD_LIM);
    assign busy      = (fifo_cnt != '0) || (state != IDLE);

    req_fifo #(
        .WIDTH ($bits(dmem_req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .din   (push_req),
        .pop   (pop),
        .dout  (head_bits),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = ACCESS;
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            writeEn       <= 1'b0;
            readEn        <= 1'b0;
            ALUMemAdd     <= '0;
            writeDataM    <= '0;
            resp_valid    <= 1'b0;
            resp_is_store <= 1'b0;
            resp_tag      <= '0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            store_count   <= '0;
            cur_is_store  <= 1'b0;
            cur_err       <= 1'b0;
            cur_tag       <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (!empty) begin
                    ALUMemAdd    <= head.addr;
                    writeDataM   <= head.wdata;
                    writeEn      <=  head.is_store && head_ok;
                    readEn       <= !head.is_store && head_ok;
                    cur_is_store <= head.is_store;
                    cur_tag      <= head.tag;
                    cur_err      <= !head_ok;
                end
                ACCESS: begin
                    writeEn       <= 1'b0;
                    readEn        <= 1'b0;
                    resp_valid    <= 1'b1;
                    resp_is_store <= cur_is_store;
                    resp_tag      <= cur_tag;
                    resp_err      <= cur_err;
                    // readEn is high only for a legal load in flight.
                    resp_data     <= readEn ? readDataW : '0;
                    if (writeEn && store_count != '1)
                        store_count <= store_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;

    typedef struct {
        bit        st;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [4:0]  tag;
    } mreq_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0, req_is_store = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_tag = '0;
    logic        writeEn, readEn, resp_valid, resp_is_store, resp_err, busy;
    logic [31:0] ALUMemAdd, writeDataM, readDataW, resp_data;
    logic [4:0]  resp_tag;
    logic [7:0]  store_count;

    always #5 CLK = ~CLK;

    data_mem_access_unit dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .writeEn(writeEn), .readEn(readEn),
        .ALUMemAdd(ALUMemAdd), .writeDataM(writeDataM), .readDataW(readDataW),
        .resp_valid(resp_valid), .resp_is_store(resp_is_store),
        .resp_tag(resp_tag), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy), .store_count(store_count)
    );

    // Data memory model: 20 words, loads read word addr+5.
    logic [31:0] mem [20];
    logic [31:0] junk = 32'hDEAD_BEEF;
    always_comb begin
        readDataW = junk;
        if (readEn && ALUMemAdd < 32'd15)
            readDataW = mem[int'(ALUMemAdd) + 5];
    end

    // Reference model state
    mreq_t     q[$];
    bit        infl_v;
    mreq_t     infl;
    bit        e_we, e_re, e_rv, e_rst, e_err;
    bit [31:0] e_addr, e_wd, e_data;
    bit [4:0]  e_tag;
    int        e_cnt;
    int        ncmp = 0, nerr = 0;

    function automatic bit legal(mreq_t r);
        return r.st ? (r.addr <= 32'd4) : (r.addr < 32'd15);
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", nm, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v, input mreq_t r, output bit acc);
        bit ok;
        RST = rst; req_valid = v; req_is_store = r.st;
        req_addr = r.addr; req_wdata = r.wd; req_tag = r.tag;
        if (!rst) chk("req_ready", req_ready, 32'(q.size() < 2));
        @(posedge CLK);
        acc = 0;
        if (rst) begin
            q.delete(); infl_v = 0;
            e_we = 0; e_re = 0; e_rv = 0; e_rst = 0; e_err = 0;
            e_addr = 0; e_wd = 0; e_data = 0; e_tag = 0; e_cnt = 0;
        end else begin
            e_rv = 0;
            acc = v && (q.size() < 2);
            if (infl_v) begin
                ok = legal(infl);
                e_we = 0; e_re = 0; e_rv = 1;
                e_rst = infl.st; e_tag = infl.tag; e_err = !ok;
                e_data = (!infl.st && ok) ? mem[int'(infl.addr) + 5] : 32'd0;
                if (infl.st && ok && e_cnt < 255) e_cnt++;
                infl_v = 0;
            end else if (q.size() > 0) begin
                infl = q.pop_front();
                infl_v = 1;
                ok = legal(infl);
                e_addr = infl.addr; e_wd = infl.wd;
                e_we = infl.st && ok; e_re = !infl.st && ok;
            end
            if (acc) q.push_back(r);
        end
        #1;
        chk("writeEn", writeEn, 32'(e_we));
        chk("readEn", readEn, 32'(e_re));
        chk("strobe_excl", 32'(writeEn & readEn), 32'd0);
        chk("ALUMemAdd", ALUMemAdd, e_addr);
        chk("writeDataM", writeDataM, e_wd);
        chk("resp_valid", resp_valid, 32'(e_rv));
        chk("resp_is_store", resp_is_store, 32'(e_rst));
        chk("resp_tag", resp_tag, 32'(e_tag));
        chk("resp_data", resp_data, e_data);
        chk("resp_err", resp_err, 32'(e_err));
        chk("store_count", store_count, 32'(e_cnt));
        chk("busy", busy, 32'((q.size() > 0) || infl_v));
        junk = $urandom;
    endtask

    task automatic idle(input int n);
        mreq_t z; bit a;
        z = '{st: 0, addr: 0, wd: 0, tag: 0};
        for (int i = 0; i < n; i++) step(0, 0, z, a);
    endtask

    task automatic send(input mreq_t r);
        bit a;
        a = 0;
        for (int i = 0; i < 20 && !a; i++) step(0, 1, r, a);
        chk("accept_timeout", 32'(a), 32'd1);
    endtask

    function automatic mreq_t mk(bit st, bit [31:0] addr, bit [31:0] wd, bit [4:0] tag);
        mreq_t r;
        r.st = st; r.addr = addr; r.wd = wd; r.tag = tag;
        return r;
    endfunction

    function automatic mreq_t rnd_req();
        mreq_t r;
        r.st = 1'($urandom); r.wd = $urandom; r.tag = 5'($urandom);
        case ($urandom_range(0, 9))
            0:       r.addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            1:       r.addr = r.st ? 32'd4 + $urandom_range(0, 1) : 32'd14 + $urandom_range(0, 1);
            default: r.addr = $urandom_range(0, 20);
        endcase
        return r;
    endfunction

    initial begin
        mreq_t z, r;
        bit a;
        for (int i = 0; i < 20; i++) mem[i] = $urandom;
        mem[8] = 32'h0000_002A;
        z = mk(0, 0, 0, 0);

        // Reset state
        step(1, 0, z, a);
        step(1, 0, z, a);
        idle(2);

        // Single legal load, then single legal store
        send(mk(0, 32'd3, 32'd0, 5'd7));
        idle(4);
        chk("load_data_42", resp_data, 32'd42);
        send(mk(1, 32'd2, 32'hFFFF_FFF6, 5'd9));
        idle(4);
        chk("store_count_1", 32'(store_count), 32'd1);

        // Back-to-back with valid held
        send(mk(0, 32'd0, 32'd0, 5'd1));
        send(mk(1, 32'd4, 32'h1234_5678, 5'd2));
        send(mk(0, 32'd14, 32'd0, 5'd3));
        idle(8);

        // Out-of-range requests, including one whose addr+5 would wrap
        send(mk(0, 32'd15, 32'd0, 5'd4));
        send(mk(1, 32'd5, 32'hAAAA_5555, 5'd5));
        send(mk(0, 32'hFFFF_FFFE, 32'd0, 5'd6));
        idle(8);

        // Reset during a load's access cycle with one request queued
        send(mk(0, 32'd1, 32'd0, 5'd10));
        send(mk(0, 32'd2, 32'd0, 5'd11));
        step(1, 0, z, a);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        idle(5);

        // Randomized traffic, holding a request until it is accepted
        r = rnd_req();
        for (int i = 0; i < 400; i++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            step(0, v, r, a);
            if (a || !v) r = rnd_req();
        end
        idle(4);

        // Saturation of the store counter
        for (int i = 0; i < 300; i++)
            send(mk(1, $urandom_range(0, 4), $urandom, 5'($urandom)));
        idle(4);
        chk("store_count_sat", 32'(store_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
